// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue and its storage.
// The fetch packet is the unit that moves from IF to ID, in order.
package inst_fetch_queue_pkg;

    localparam int IFQ_DEPTH = 8;

    // Canonical NOP for bubble insertion by downstream stages.
    localparam logic [31:0] NOP_INSTR = 32'h0340_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
    } fetch_pkt_t;

endpackage

// File: rtl/ifq_storage.sv
// Register-array storage for the fetch queue: one write port, one async read port.
// Contents are deliberately not reset; validity is tracked by the pointer logic.
module ifq_storage
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  fetch_pkt_t       wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output fetch_pkt_t       rdata_o
);

    fetch_pkt_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order instruction buffer between IF and ID with single-cycle flush.
// Handshake: a transfer happens on a cycle where valid && ready are both high (and flush is low);
// the producer holds its payload stable until that cycle, and ready never depends on valid.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             in_excp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic             out_excp,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic       push;
    logic       pop;
    fetch_pkt_t wr_pkt;
    fetch_pkt_t head_pkt;

    // Full blocks pushes even when a pop is also happening this cycle.
    assign in_ready  = !rst && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign wr_pkt = '{pc: in_pc, instr: in_instr, excp: in_excp};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_pkt),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_pkt)
    );

    // Zeroed when empty so the decoders see a deterministic word, not stale storage.
    assign out_pc    = out_valid ? head_pkt.pc    : '0;
    assign out_instr = out_valid ? head_pkt.instr : '0;
    assign out_excp  = out_valid ? head_pkt.excp  : 1'b0;
    assign count     = count_q;

endmodule
